id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage RV32 core, with load-use hazard detection and write-back bypass on register read.
- Directly upstream of the EX-stage forwarding unit: it produces RS1Addr_EX/RS2Addr_EX, the operand data and control that the forwarding muxes consume.
- Inserts bubbles on load-use hazards and branch flushes, and counts inserted bubbles for performance monitoring.

---
 rtl/id_ex_stage.sv | 159 +++++++++++++++
 tb/tb_id_ex_stage.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the 5-stage RV32 core.
// Detects load-use hazards against the instruction in EX, bypasses the
// write-back result into the captured operands, inserts bubbles on hazards
// and branch flushes, and keeps a saturating count of hazard bubbles.
//
// Flow semantics: there is no ready/valid handshake here. Valid_ID marks a
// real instruction in ID. Valid_EX marks a real instruction in EX. Stall_ID
// asks upstream to hold PC and IF/ID for one cycle while EX takes a bubble.
// Stall_EXT freezes this register unconditionally.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              Valid_ID,
    input  logic [4:0]        RS1Addr_ID,
    input  logic [4:0]        RS2Addr_ID,
    input  logic [4:0]        RDAddr_ID,
    input  logic [XLEN-1:0]   RS1Data_ID,
    input  logic [XLEN-1:0]   RS2Data_ID,
    input  logic [XLEN-1:0]   Imm_ID,
    input  logic [9:0]        Funct_ID,
    input  logic [1:0]        ALUOp_ID,
    input  logic              ALUSrc_ID,
    input  logic              RegWrite_ID,
    input  logic              MemRead_ID,
    input  logic              MemWrite_ID,
    input  logic              MemToReg_ID,
    input  logic              Flush_ID,
    input  logic              Stall_EXT,
    input  logic [4:0]        RDAddr_WB,
    input  logic              RegWrite_WB,
    input  logic [XLEN-1:0]   WBData_WB,
    output logic              Stall_ID,
    output logic              Valid_EX,
    output logic [4:0]        RS1Addr_EX,
    output logic [4:0]        RS2Addr_EX,
    output logic [4:0]        RDAddr_EX,
    output logic [XLEN-1:0]   RS1Data_EX,
    output logic [XLEN-1:0]   RS2Data_EX,
    output logic [XLEN-1:0]   Imm_EX,
    output logic [9:0]        Funct_EX,
    output logic [1:0]        ALUOp_EX,
    output logic              ALUSrc_EX,
    output logic              RegWrite_EX,
    output logic              MemRead_EX,
    output logic              MemWrite_EX,
    output logic              MemToReg_EX,
    output logic [CNT_W-1:0]  BubbleCnt
);

    // Everything held in EX, kept together so a bubble is simply all zeros.
    typedef struct packed {
        logic              valid;
        logic [4:0]        rs1_addr;
        logic [4:0]        rs2_addr;
        logic [4:0]        rd_addr;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [9:0]        funct;
        logic [1:0]        alu_op;
        logic              alu_src;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } ex_t;

    ex_t              ex_q;
    ex_t              ex_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             load_use;
    logic             wb_hit1;
    logic             wb_hit2;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;

    // Load-use hazard: the load in EX writes a register that ID reads.
    // x0 never creates a hazard; a flush discards ID so there is nothing to stall.
    always_comb begin
        load_use = Valid_ID & ex_q.valid & ex_q.mem_read & (ex_q.rd_addr != 5'd0) &
                   ((ex_q.rd_addr == RS1Addr_ID) | (ex_q.rd_addr == RS2Addr_ID)) &
                   ~Flush_ID;
    end

    assign Stall_ID = load_use;

    // Write-back bypass so a value written this cycle is seen by the reader in ID.
    always_comb begin
        wb_hit1 = RegWrite_WB & (RDAddr_WB != 5'd0) & (RDAddr_WB == RS1Addr_ID);
        wb_hit2 = RegWrite_WB & (RDAddr_WB != 5'd0) & (RDAddr_WB == RS2Addr_ID);
        rs1_val = wb_hit1 ? WBData_WB : RS1Data_ID;
        rs2_val = wb_hit2 ? WBData_WB : RS2Data_ID;
    end

    // Next EX contents and counter: freeze, then flush, then hazard bubble, then load.
    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (Stall_EXT) begin
            ex_d  = ex_q;
            cnt_d = cnt_q;
        end else if (Flush_ID) begin
            ex_d = '0;
        end else if (load_use) begin
            ex_d = '0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            ex_d.valid      = Valid_ID;
            ex_d.rs1_addr   = RS1Addr_ID;
            ex_d.rs2_addr   = RS2Addr_ID;
            ex_d.rd_addr    = RDAddr_ID;
            ex_d.rs1_data   = rs1_val;
            ex_d.rs2_data   = rs2_val;
            ex_d.imm        = Imm_ID;
            ex_d.funct      = Funct_ID;
            // Control of a non-instruction is forced off so nothing can fire from it.
            ex_d.alu_op     = Valid_ID ? ALUOp_ID : 2'b00;
            ex_d.alu_src    = Valid_ID & ALUSrc_ID;
            ex_d.reg_write  = Valid_ID & RegWrite_ID;
            ex_d.mem_read   = Valid_ID & MemRead_ID;
            ex_d.mem_write  = Valid_ID & MemWrite_ID;
            ex_d.mem_to_reg = Valid_ID & MemToReg_ID;
        end
    end

    // Pipeline register and bubble counter with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ex_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign Valid_EX    = ex_q.valid;
    assign RS1Addr_EX  = ex_q.rs1_addr;
    assign RS2Addr_EX  = ex_q.rs2_addr;
    assign RDAddr_EX   = ex_q.rd_addr;
    assign RS1Data_EX  = ex_q.rs1_data;
    assign RS2Data_EX  = ex_q.rs2_data;
    assign Imm_EX      = ex_q.imm;
    assign Funct_EX    = ex_q.funct;
    assign ALUOp_EX    = ex_q.alu_op;
    assign ALUSrc_EX   = ex_q.alu_src;
    assign RegWrite_EX = ex_q.reg_write;
    assign MemRead_EX  = ex_q.mem_read;
    assign MemWrite_EX = ex_q.mem_write;
    assign MemToReg_EX = ex_q.mem_to_reg;
    assign BubbleCnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed testbench for id_ex_stage: reset, straight load, load-use bubble,
// x0 hazard, write-back bypass, flush/freeze priority, counter saturation
// (second instance with CNT_W=2) and reset during a stall.
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        Valid_ID;
    logic [4:0]  RS1Addr_ID, RS2Addr_ID, RDAddr_ID;
    logic [31:0] RS1Data_ID, RS2Data_ID, Imm_ID;
    logic [9:0]  Funct_ID;
    logic [1:0]  ALUOp_ID;
    logic        ALUSrc_ID, RegWrite_ID, MemRead_ID, MemWrite_ID, MemToReg_ID;
    logic        Flush_ID, Stall_EXT;
    logic [4:0]  RDAddr_WB;
    logic        RegWrite_WB;
    logic [31:0] WBData_WB;

    logic        Stall_ID, Valid_EX;
    logic [4:0]  RS1Addr_EX, RS2Addr_EX, RDAddr_EX;
    logic [31:0] RS1Data_EX, RS2Data_EX, Imm_EX;
    logic [9:0]  Funct_EX;
    logic [1:0]  ALUOp_EX;
    logic        ALUSrc_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX;
    logic [15:0] BubbleCnt;

    logic        s_stall, s_valid;
    logic [4:0]  s_rs1a, s_rs2a, s_rda;
    logic [31:0] s_rs1d, s_rs2d, s_imm;
    logic [9:0]  s_funct;
    logic [1:0]  s_aluop;
    logic        s_alusrc, s_rw, s_mr, s_mw, s_m2r;
    logic [1:0]  s_cnt;

    int checks   = 0;
    int failures = 0;

    // Clock
    always #5 clk_i = ~clk_i;

    id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .Valid_ID(Valid_ID),
        .RS1Addr_ID(RS1Addr_ID), .RS2Addr_ID(RS2Addr_ID), .RDAddr_ID(RDAddr_ID),
        .RS1Data_ID(RS1Data_ID), .RS2Data_ID(RS2Data_ID), .Imm_ID(Imm_ID),
        .Funct_ID(Funct_ID), .ALUOp_ID(ALUOp_ID), .ALUSrc_ID(ALUSrc_ID),
        .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID),
        .MemToReg_ID(MemToReg_ID), .Flush_ID(Flush_ID), .Stall_EXT(Stall_EXT),
        .RDAddr_WB(RDAddr_WB), .RegWrite_WB(RegWrite_WB), .WBData_WB(WBData_WB),
        .Stall_ID(Stall_ID), .Valid_EX(Valid_EX),
        .RS1Addr_EX(RS1Addr_EX), .RS2Addr_EX(RS2Addr_EX), .RDAddr_EX(RDAddr_EX),
        .RS1Data_EX(RS1Data_EX), .RS2Data_EX(RS2Data_EX), .Imm_EX(Imm_EX),
        .Funct_EX(Funct_EX), .ALUOp_EX(ALUOp_EX), .ALUSrc_EX(ALUSrc_EX),
        .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
        .MemToReg_EX(MemToReg_EX), .BubbleCnt(BubbleCnt)
    );

    id_ex_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
        .clk_i(clk_i), .rst_i(rst_i), .Valid_ID(Valid_ID),
        .RS1Addr_ID(RS1Addr_ID), .RS2Addr_ID(RS2Addr_ID), .RDAddr_ID(RDAddr_ID),
        .RS1Data_ID(RS1Data_ID), .RS2Data_ID(RS2Data_ID), .Imm_ID(Imm_ID),
        .Funct_ID(Funct_ID), .ALUOp_ID(ALUOp_ID), .ALUSrc_ID(ALUSrc_ID),
        .RegWrite_ID(RegWrite_ID), .MemRead_ID(MemRead_ID), .MemWrite_ID(MemWrite_ID),
        .MemToReg_ID(MemToReg_ID), .Flush_ID(Flush_ID), .Stall_EXT(Stall_EXT),
        .RDAddr_WB(RDAddr_WB), .RegWrite_WB(RegWrite_WB), .WBData_WB(WBData_WB),
        .Stall_ID(s_stall), .Valid_EX(s_valid),
        .RS1Addr_EX(s_rs1a), .RS2Addr_EX(s_rs2a), .RDAddr_EX(s_rda),
        .RS1Data_EX(s_rs1d), .RS2Data_EX(s_rs2d), .Imm_EX(s_imm),
        .Funct_EX(s_funct), .ALUOp_EX(s_aluop), .ALUSrc_EX(s_alusrc),
        .RegWrite_EX(s_rw), .MemRead_EX(s_mr), .MemWrite_EX(s_mw),
        .MemToReg_EX(s_m2r), .BubbleCnt(s_cnt)
    );

    // Scoreboard check: one immediate assertion per comparison.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Driver: quiet ID and WB inputs.
    task automatic drive_idle();
        Valid_ID = 0; RS1Addr_ID = 0; RS2Addr_ID = 0; RDAddr_ID = 0;
        RS1Data_ID = 0; RS2Data_ID = 0; Imm_ID = 0; Funct_ID = 0; ALUOp_ID = 0;
        ALUSrc_ID = 0; RegWrite_ID = 0; MemRead_ID = 0; MemWrite_ID = 0; MemToReg_ID = 0;
        Flush_ID = 0; Stall_EXT = 0; RDAddr_WB = 0; RegWrite_WB = 0; WBData_WB = 0;
    endtask

    // Driver: a load word "lw x<rd>, 0(x1)" sitting in ID.
    task automatic drive_lw(input logic [4:0] rd);
        drive_idle();
        Valid_ID = 1; RS1Addr_ID = 5'd1; RDAddr_ID = rd; ALUSrc_ID = 1;
        RegWrite_ID = 1; MemRead_ID = 1; MemToReg_ID = 1;
    endtask

    // Driver: an R-type add in ID.
    task automatic drive_add(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
        drive_idle();
        Valid_ID = 1; RS1Addr_ID = rs1; RS2Addr_ID = rs2; RDAddr_ID = rd;
        RS1Data_ID = 32'h100; RS2Data_ID = 32'h200; ALUOp_ID = 2'b10; RegWrite_ID = 1;
    endtask

    // Check that EX holds a bubble.
    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, 32'(Valid_EX), 32'd0);
        chk({tag, "_rd"},    32'(RDAddr_EX), 32'd0);
        chk({tag, "_rs2a"},  32'(RS2Addr_EX), 32'd0);
        chk({tag, "_rw"},    32'(RegWrite_EX), 32'd0);
        chk({tag, "_mr"},    32'(MemRead_EX), 32'd0);
    endtask

    initial begin
        // Reset with random inputs for two edges
        drive_idle();
        rst_i = 0;
        Valid_ID = 1; MemRead_ID = 1; RegWrite_ID = 1; MemWrite_ID = 1;
        RDAddr_ID = 5'($urandom_range(1, 31)); RS1Addr_ID = 5'($urandom_range(0, 31));
        RS1Data_ID = $urandom; RS2Data_ID = $urandom; Imm_ID = $urandom;
        Funct_ID = 10'($urandom_range(0, 1023)); ALUOp_ID = 2'($urandom_range(0, 3));
        step();
        step();
        chk("rst_valid", 32'(Valid_EX), 32'd0);
        chk("rst_rd",    32'(RDAddr_EX), 32'd0);
        chk("rst_rs1d",  RS1Data_EX, 32'd0);
        chk("rst_imm",   Imm_EX, 32'd0);
        chk("rst_funct", 32'(Funct_EX), 32'd0);
        chk("rst_ctl",   32'({RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrc_EX}), 32'd0);
        chk("rst_cnt",   32'(BubbleCnt), 32'd0);
        chk("rst_stall", 32'(Stall_ID), 32'd0);

        // Straight load
        rst_i = 1;
        drive_idle();
        Valid_ID = 1; RS1Addr_ID = 5; RS2Addr_ID = 6; RDAddr_ID = 7;
        RS1Data_ID = 32'h11; RS2Data_ID = 32'h22; Imm_ID = 32'hFFFF_FFF0;
        Funct_ID = 10'h123; ALUOp_ID = 2'b10; RegWrite_ID = 1;
        step();
        chk("ld_valid", 32'(Valid_EX), 32'd1);
        chk("ld_rs1a",  32'(RS1Addr_EX), 32'd5);
        chk("ld_rs2a",  32'(RS2Addr_EX), 32'd6);
        chk("ld_rd",    32'(RDAddr_EX), 32'd7);
        chk("ld_rs1d",  RS1Data_EX, 32'h11);
        chk("ld_rs2d",  RS2Data_EX, 32'h22);
        chk("ld_imm",   Imm_EX, 32'hFFFF_FFF0);
        chk("ld_funct", 32'(Funct_EX), 32'h123);
        chk("ld_aluop", 32'(ALUOp_EX), 32'd2);
        chk("ld_ctl",   32'({RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, ALUSrc_EX}), 32'b10000);

        // Load-use: lw x3 then add x8, x4, x3
        drive_lw(5'd3);
        step();
        chk("lu_lw_mr", 32'(MemRead_EX), 32'd1);
        drive_add(5'd4, 5'd3, 5'd8);
        #1;
        chk("lu_stall", 32'(Stall_ID), 32'd1);
        step();
        chk_bubble("lu_bub");
        chk("lu_cnt", 32'(BubbleCnt), 32'd1);
        chk("lu_stall_drop", 32'(Stall_ID), 32'd0);
        step();
        chk("lu_add_valid", 32'(Valid_EX), 32'd1);
        chk("lu_add_rd",    32'(RDAddr_EX), 32'd8);
        chk("lu_add_rs2a",  32'(RS2Addr_EX), 32'd3);

        // Hazard on x0: lw x0 then an instruction reading x0
        drive_lw(5'd0);
        step();
        drive_add(5'd0, 5'd0, 5'd9);
        #1;
        chk("x0_stall", 32'(Stall_ID), 32'd0);
        step();
        chk("x0_valid", 32'(Valid_EX), 32'd1);
        chk("x0_rd",    32'(RDAddr_EX), 32'd9);
        chk("x0_cnt",   32'(BubbleCnt), 32'd1);

        // WB bypass on both operands
        drive_add(5'd9, 5'd9, 5'd10);
        RS1Data_ID = 32'h0; RS2Data_ID = 32'h5;
        RegWrite_WB = 1; RDAddr_WB = 5'd9; WBData_WB = 32'hDEAD_BEEF;
        step();
        chk("byp_rs1", RS1Data_EX, 32'hDEAD_BEEF);
        chk("byp_rs2", RS2Data_EX, 32'hDEAD_BEEF);
        // x0 is never bypassed
        drive_add(5'd0, 5'd6, 5'd10);
        RS1Data_ID = 32'h0; RS2Data_ID = 32'h66;
        RegWrite_WB = 1; RDAddr_WB = 5'd0; WBData_WB = 32'hDEAD_BEEF;
        step();
        chk("byp_x0_rs1", RS1Data_EX, 32'h0);
        chk("byp_x0_rs2", RS2Data_EX, 32'h66);
        // No bypass without RegWrite_WB
        drive_add(5'd9, 5'd6, 5'd10);
        RS1Data_ID = 32'h77; RDAddr_WB = 5'd9; WBData_WB = 32'hDEAD_BEEF;
        step();
        chk("byp_nowr", RS1Data_EX, 32'h77);

        // Flush during a load-use hazard: bubble, no stall, no count
        drive_lw(5'd3);
        step();
        drive_add(5'd1, 5'd3, 5'd11);
        Flush_ID = 1;
        #1;
        chk("fl_stall", 32'(Stall_ID), 32'd0);
        step();
        chk_bubble("fl_bub");
        chk("fl_cnt", 32'(BubbleCnt), 32'd1);

        // Freeze during a hazard for three cycles, then exactly one bubble
        drive_lw(5'd3);
        step();
        drive_add(5'd3, 5'd2, 5'd12);
        Stall_EXT = 1;
        #1;
        chk("fz_stall", 32'(Stall_ID), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fz_valid", 32'(Valid_EX), 32'd1);
            chk("fz_rd",    32'(RDAddr_EX), 32'd3);
            chk("fz_mr",    32'(MemRead_EX), 32'd1);
            chk("fz_cnt",   32'(BubbleCnt), 32'd1);
            chk("fz_hold_stall", 32'(Stall_ID), 32'd1);
        end
        Stall_EXT = 0;
        step();
        chk_bubble("fz_bub");
        chk("fz_cnt_after", 32'(BubbleCnt), 32'd2);
        step();
        chk("fz_add_valid", 32'(Valid_EX), 32'd1);
        chk("fz_add_rd",    32'(RDAddr_EX), 32'd12);
        chk("fz_cnt_hold",  32'(BubbleCnt), 32'd2);

        // Three more hazards: five in total
        for (int i = 0; i < 3; i++) begin
            drive_lw(5'd4);
            step();
            drive_add(5'd4, 5'd0, 5'd13);
            step();
        end
        chk("sat_cnt16", 32'(BubbleCnt), 32'd5);
        chk("sat_cnt2",  32'(s_cnt), 32'd3);

        // Reset while a stall is asserted
        drive_lw(5'd3);
        step();
        drive_add(5'd3, 5'd3, 5'd14);
        #1;
        chk("rs_pre_stall", 32'(Stall_ID), 32'd1);
        rst_i = 0;
        step();
        chk("rs_valid", 32'(Valid_EX), 32'd0);
        chk("rs_mr",    32'(MemRead_EX), 32'd0);
        chk("rs_cnt",   32'(BubbleCnt), 32'd0);
        chk("rs_cnt2",  32'(s_cnt), 32'd0);
        chk("rs_stall", 32'(Stall_ID), 32'd0);
        rst_i = 1;
        drive_idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
